// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmem_state_e;

  localparam int unsigned TIMEOUT_CYCLES = 255;
  localparam logic [15:0] DEAD_DATA      = 16'hDEAD;

endpackage

// File: rtl/dmem_timer.sv
// Access watchdog: counts ACCESS cycles without ack and flags the last one.
module dmem_timer
  import dmem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Clear wins over enable so a new access always starts from zero.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (enable) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Asserted during the cycle in which the count would reach TIMEOUT_CYCLES.
  assign expired = enable && (count_q == LAST_COUNT);

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage bus responder: stalls the pipeline while a load/store runs on the bus.
// Optional access timeout is compiled in with DMEM_TIMEOUT_EN.
module dmem_responder
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic        mem_sel,
  input  logic [15:0] d_addr,
  input  logic [15:0] wrt_data,
  output logic        stall,
  output logic [15:0] rd_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic        bus_sel,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [15:0] bus_rdata,
  output logic        bus_err
);

  dmem_state_e state_q, state_d;

  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic        bus_sel_q, bus_sel_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic [15:0] bus_wdata_q, bus_wdata_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        bus_err_d;
  logic        stall_s;
  logic        req_s;
  logic        timeout_s;

  assign req_s = mem_re | mem_we;

`ifdef DMEM_TIMEOUT_EN
  logic bus_err_q;

  dmem_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   ((state_q == IDLE) && req_s),
    .enable  ((state_q == ACCESS) && !bus_ack),
    .expired (timeout_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign timeout_s = 1'b0;
  assign bus_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_s) state_d = ACCESS;
        else       state_d = IDLE;
      end
      ACCESS: begin
        if (bus_ack || timeout_s) state_d = RESP;
        else                      state_d = ACCESS;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stall is combinational so the requesting instruction freezes in its first cycle.
  always_comb begin
    stall_s = 1'b0;
    case (state_q)
      IDLE:    stall_s = req_s;
      ACCESS:  stall_s = 1'b1;
      RESP:    stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
  end

  assign stall = rst_n & stall_s;

  // Bus request registers are captured once in IDLE and frozen until completion.
  always_comb begin
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rd_data_d   = rd_data_q;
    bus_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we;
          bus_sel_d   = mem_sel;
          bus_addr_d  = d_addr;
          bus_wdata_d = wrt_data;
        end else begin
          bus_req_d   = 1'b0;
        end
      end
      ACCESS: begin
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) rd_data_d = bus_rdata;
          else           rd_data_d = rd_data_q;
        end else if (timeout_s) begin
          bus_req_d = 1'b0;
          rd_data_d = DEAD_DATA;
          bus_err_d = 1'b1;
        end else begin
          bus_req_d = 1'b1;
        end
      end
      RESP:    bus_req_d = 1'b0;
      default: bus_req_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= 1'b0;
      bus_addr_q  <= 16'h0000;
      bus_wdata_q <= 16'h0000;
      rd_data_q   <= 16'h0000;
    end else begin
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_sel   = bus_sel_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign rd_data   = rd_data_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have port: clk  input  1  single clock for the whole block, rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port: mem_re  input  1  load request from the EX/MEM stage.
REQ-004 SHALL have port: mem_we  input  1  store request from the EX/MEM stage.
REQ-005 SHALL have port: mem_sel  input  1  space select, 0 = data RAM, 1 = I/O space.
REQ-006 SHALL have port: d_addr  input  16  access address.
REQ-007 SHALL have port: wrt_data  input  16  store data.
REQ-008 SHALL have port: stall  output  1  holds IF/ID, ID/EX and EX/MEM; forces a MEM/WB bubble.
REQ-009 SHALL have port: rd_data  output  16  load data to the MEM/WB stage.
REQ-010 SHALL have port: bus_req  output  1  memory bus request.
REQ-011 SHALL have port: bus_we, bus_sel  output  1 each  registered copies of the request type.
REQ-012 SHALL have port: bus_addr, bus_wdata  output  16 each  registered copies of the request address and data.
REQ-013 SHALL have port: bus_ack  input  1  bus completion, one-cycle pulse.
REQ-014 SHALL have port: bus_rdata  input  16  read data, valid while bus_ack=1.
REQ-015 SHALL have port: bus_err  output  1  timeout pulse; tied 0 when timeout is compiled out.

Function
REQ-016 SHALL implement three states: IDLE, ACCESS, RESP.
REQ-017 In IDLE with (mem_re|mem_we)=1: SHALL drive stall=1 combinationally in the same cycle, latch the request into the bus_* registers, set bus_req=1 and go to ACCESS.
REQ-018 In IDLE with no request: stall=0, bus_req=0, and the FSM SHALL stay in IDLE.
REQ-019 mem_re=mem_we=1 SHALL be treated as a store (bus_we=1).
REQ-020 In ACCESS: stall=1 and bus_req/bus_* SHALL be held stable until bus_ack=1.
REQ-021 On bus_ack=1 in ACCESS: SHALL register rd_data<=bus_rdata (loads only; stores leave rd_data unchanged), drop bus_req at the next edge and go to RESP.
REQ-022 In RESP: stall=0 for exactly one cycle; request inputs SHALL be ignored (they are still the completed access); next state IDLE.
REQ-023 Minimum latency: request in cycle 0, bus_req in cycle 1, ack in cycle 1, RESP in cycle 2, i.e. 2 stall cycles.
REQ-024 bus_ack outside ACCESS SHALL be ignored.
REQ-025 rd_data SHALL hold its last value until the next completed load.
REQ-026 Back-to-back requests SHALL incur one IDLE cycle between accesses; the first cycle of each new request stalls.

Reset
REQ-027 rst_n=0 SHALL force IDLE, with stall=0, bus_req=0, bus_we=0, bus_sel=0, bus_addr=0, bus_wdata=0, rd_data=0 and bus_err=0, regardless of clk.
REQ-028 Reset mid-ACCESS SHALL drop bus_req immediately; the outstanding access is abandoned and a late bus_ack is ignored.

Configuration
REQ-029 Macro DMEM_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack; when it reaches 255 the FSM SHALL go to RESP with rd_data=16'hDEAD, pulse bus_err for 1 cycle and drop bus_req.
REQ-030 Macro DMEM_TIMEOUT_EN undefined: ACCESS SHALL wait indefinitely, no counter logic SHALL exist, and bus_err SHALL be constant 0.

Structure
REQ-031 Package dmem_pkg SHALL hold the state enum (IDLE/ACCESS/RESP), TIMEOUT_CYCLES=255 and DEAD_DATA=16'hDEAD.
REQ-032 The timeout counter SHALL be sub-module dmem_timer (clear, enable, expired), instantiated only under DMEM_TIMEOUT_EN.

Verification
REQ-033 Load: mem_re=1, d_addr=16'h2004, bus_ack in the 1st ACCESS cycle with bus_rdata=16'hBEEF -> stall high 2 cycles, rd_data=16'hBEEF in RESP, bus_addr=16'h2004.
REQ-034 Store with a slow bus: mem_we=1, wrt_data=16'h1234, mem_sel=1, ack after 5 cycles -> stall high 6 cycles, bus_we=1, bus_sel=1, bus_wdata=16'h1234 stable throughout, rd_data unchanged.
REQ-035 Back-to-back: two loads in consecutive instructions -> exactly one IDLE cycle between the two bus_req pulses, and no duplicate bus request for the first load during RESP.
REQ-036 Reset mid-ACCESS: rst_n=0 for 1 cycle -> bus_req and stall 0 immediately; a later bus_ack causes no state change.
REQ-037 Simultaneous mem_re=mem_we=1 -> bus_we=1 and rd_data unchanged.
REQ-038 With DMEM_TIMEOUT_EN and no ack -> after 255 ACCESS cycles, rd_data=16'hDEAD, bus_err pulses once and stall falls.
